// File: rtl/psx_pkg.sv
// Shared constants, state type and reply table for the fake PSX digital pad.
// Byte indices follow the order of a standard digital-pad poll.
package psx_pkg;

    localparam logic [7:0] PSX_ADDR_PAD   = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_ID_MARK    = 8'h5A;
    localparam logic [7:0] PSX_IDLE_BYTE  = 8'hFF;

    localparam logic [2:0] BYTE_IDX0 = 3'd0;
    localparam logic [2:0] BYTE_IDX1 = 3'd1;
    localparam logic [2:0] BYTE_IDX2 = 3'd2;
    localparam logic [2:0] BYTE_IDX3 = 3'd3;
    localparam logic [2:0] BYTE_IDX4 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_IGNORE
    } psx_state_e;

    function automatic logic [7:0] psx_reply(
        input logic [2:0]  idx,
        input logic [15:0] btn
    );
        logic [7:0] r;
        case (idx)
            BYTE_IDX0: r = PSX_IDLE_BYTE;
            BYTE_IDX1: r = PSX_ID_DIGITAL;
            BYTE_IDX2: r = PSX_ID_MARK;
            BYTE_IDX3: r = btn[7:0];
            BYTE_IDX4: r = btn[15:8];
            default:   r = PSX_IDLE_BYTE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// Multi-flop synchronizer with registered previous level and edge pulses.
// Edges are suppressed until the chain holds real pin samples after reset.
module psx_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   prev_q;
    logic                   primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            fill_q <= '0;
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A pin held at a non-idle level through reset must not look like an edge.
    assign primed  = fill_q[SYNC_STAGES];
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = primed & level_o & ~prev_q;
    assign fall_o  = primed & ~level_o & prev_q;

endmodule

// File: rtl/fake_psx_pad.sv
// PSX digital-pad responder: shifts command bytes in, replies LSB first,
// and emits the per-byte ack pulse from an independent timer.
module fake_psx_pad #(
    parameter int ACK_DELAY   = 4,
    parameter int ACK_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] buttons,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic        att,
    output logic        data,
    output logic        ack,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        poll_done
);

    import psx_pkg::*;

    localparam int TW = $clog2(ACK_DELAY + ACK_WIDTH + 1);
    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [TW-1:0] T_ON  = TW'(ACK_DELAY);
    localparam logic [TW-1:0] T_END = TW'(ACK_DELAY + ACK_WIDTH);

    logic psx_lvl, psx_rise, psx_fall;
    logic att_lvl, att_rise, att_fall;
    logic cmd_lvl, cmd_rise, cmd_fall;
    logic unused_sig;

    psx_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [2:0]    byte_cnt_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_byte_q;
    logic [15:0]   btn_q;
    logic [TW-1:0] timer_q;
    logic          data_q;
    logic          ack_q;
    logic          rx_valid_q;
    logic          poll_done_q;

    logic [7:0] tx_byte;
    logic [7:0] rx_shift_d;
    logic       bad_hdr;

    psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .din_i   (psx_clk),
        .level_o (psx_lvl),
        .rise_o  (psx_rise),
        .fall_o  (psx_fall)
    );

    psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_att (
        .clk     (clk),
        .rst     (rst),
        .din_i   (att),
        .level_o (att_lvl),
        .rise_o  (att_rise),
        .fall_o  (att_fall)
    );

    psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cmd (
        .clk     (clk),
        .rst     (rst),
        .din_i   (cmd),
        .level_o (cmd_lvl),
        .rise_o  (cmd_rise),
        .fall_o  (cmd_fall)
    );

    assign unused_sig = ^{psx_lvl, att_lvl, cmd_rise, cmd_fall};

    always_comb begin
        tx_byte    = psx_reply(byte_cnt_q, btn_q);
        rx_shift_d = {cmd_lvl, rx_shift_q[7:1]};
        bad_hdr    = ((byte_cnt_q == BYTE_IDX0) && (rx_shift_d != PSX_ADDR_PAD))
                  || ((byte_cnt_q == BYTE_IDX1) && (rx_shift_d != PSX_CMD_POLL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            btn_q       <= '1;
            timer_q     <= '0;
            data_q      <= 1'b1;
            ack_q       <= 1'b1;
            rx_valid_q  <= 1'b0;
            poll_done_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            poll_done_q <= 1'b0;

            // Ack timer runs on its own; the shift path keeps going meanwhile.
            if (timer_q != '0) begin
                ack_q   <= !((timer_q >= T_ON) && (timer_q < T_END));
                timer_q <= (timer_q == T_END) ? '0 : timer_q + T_ONE;
            end

            if (att_rise) begin
                state_q    <= ST_IDLE;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                rx_shift_q <= '0;
                timer_q    <= '0;
                data_q     <= 1'b1;
                ack_q      <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (att_fall) begin
                            state_q    <= ST_SHIFT;
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= '0;
                            rx_shift_q <= '0;
                            btn_q      <= buttons;
                            if (psx_fall) begin
                                data_q <= PSX_IDLE_BYTE[0];
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (psx_fall) begin
                            data_q <= tx_byte[bit_cnt_q];
                        end
                        if (psx_rise) begin
                            rx_shift_q <= rx_shift_d;
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_byte_q  <= rx_shift_d;
                                rx_valid_q <= 1'b1;
                                byte_cnt_q <= byte_cnt_q + 3'd1;
                                if (bad_hdr) begin
                                    state_q <= ST_IGNORE;
                                    data_q  <= 1'b1;
                                end else if (byte_cnt_q == BYTE_IDX4) begin
                                    state_q     <= ST_IGNORE;
                                    data_q      <= 1'b1;
                                    poll_done_q <= 1'b1;
                                end else begin
                                    timer_q <= T_ONE;
                                    ack_q   <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_IGNORE: begin
                        data_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        data_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign data      = data_q;
    assign ack       = ack_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign poll_done = poll_done_q;

endmodule
